i2c_byte_tx: RTL and testbench

I2C_BYTE_TX -- requirements
Module: i2c_byte_tx

---
 rtl/i2c_byte_tx.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_byte_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2c_byte_tx
// Description : I2C master byte transmitter. One accepted start produces a
//               complete frame: START, 8 data bits MSB first, ACK slot and
//               STOP. SCL/SDA are open-drain: *_oe = 1 pulls the line low.
//               Time advances in SCL quarter periods of CLK_DIV clk cycles.
//               A frame is 42 quarters long (2 START + 32 BIT + 4 ACK +
//               4 STOP) when SCL is not stretched.
// Parameters  : CLK_DIV  clk cycles per SCL quarter period (2..65535)
// Macro       : I2C_STRETCH_EN  when defined, the quarter counter holds in
//               Q2 of BIT/ACK/STOP while scl_in reads low (clock stretching).
//               When undefined, scl_in is ignored.
// Ports       : clk      clock, rising edge
//               rst      synchronous active-high reset
//               start    one-cycle request to send a byte (accepted when idle)
//               data     byte to send, latched on an accepted start
//               sda_in   sampled SDA level (slave ACK/NACK)
//               scl_in   sampled SCL level (stretch feature only)
//               scl_oe   1 = drive SCL low
//               sda_oe   1 = drive SDA low
//               busy     frame in progress
//               done     one-cycle frame-complete pulse
//               ack_err  1 = slave NACKed the last frame
// Revision    : 1.0  initial release
// ============================================================================
module i2c_byte_tx #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic [15:0] C_QLAST = 16'(CLK_DIV - 1);

  state_t      state_q,   state_d;
  logic [15:0] qcnt_q,    qcnt_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,   shift_d;
  logic        scl_oe_q,  scl_oe_d;
  logic        sda_oe_q,  sda_oe_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic        ack_err_q, ack_err_d;

  logic hold;
  logic q_end;

`ifdef I2C_STRETCH_EN
  // A slave holding SCL low while we have released it freezes the clock
  // in the high-going quarter of every SCL pulse.
  always_comb begin
    hold = ((state_q == ST_BIT) || (state_q == ST_ACK) || (state_q == ST_STOP))
           && (quarter_q == 2'd2) && !scl_in;
  end
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold          = 1'b0;
`endif

  assign q_end = (qcnt_q == C_QLAST) && !hold;

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    if (state_q == ST_IDLE) begin
      qcnt_d    = 16'd0;
      quarter_d = 2'd0;
      if (start) begin
        state_d   = ST_START;
        shift_d   = data;
        bit_cnt_d = 3'd0;
        ack_err_d = 1'b0;
      end
    end else begin
      if (!hold) begin
        qcnt_d = q_end ? 16'd0 : qcnt_q + 16'd1;
      end
      if (q_end) begin
        quarter_d = quarter_q + 2'd1;
        case (state_q)
          ST_START: begin
            if (quarter_q == 2'd1) begin
              state_d   = ST_BIT;
              quarter_d = 2'd0;
            end
          end
          ST_BIT: begin
            if (quarter_q == 2'd3) begin
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_d = ST_ACK;
              end
            end
          end
          ST_ACK: begin
            // Sample on the last cycle of the SCL-high quarter.
            if (quarter_q == 2'd2) begin
              ack_err_d = sda_in;
            end else if (quarter_q == 2'd3) begin
              state_d = ST_STOP;
            end
          end
          ST_STOP: begin
            if (quarter_q == 2'd3) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Outputs are decoded from the next state so that the registered
    // line controls line up with the state/quarter registers.
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      ST_START: begin
        sda_oe_d = 1'b1;
        scl_oe_d = (quarter_d == 2'd1);
      end
      ST_BIT: begin
        scl_oe_d = !quarter_d[1];
        sda_oe_d = !shift_d[7];
      end
      ST_ACK: begin
        scl_oe_d = !quarter_d[1];
      end
      ST_STOP: begin
        scl_oe_d = !quarter_d[1];
        sda_oe_d = (quarter_d != 2'd3);
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      qcnt_q    <= 16'd0;
      quarter_q <= 2'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_byte_tx
// Description : Self-checking bench for i2c_byte_tx (CLK_DIV = 4). A table of
//               byte frames is sent and checked for busy length, bits seen
//               at each SCL release, done pulse count and ack_err. Extra
//               hand sequences cover reset mid-frame, reset/start priority
//               and back-to-back frames started in the done cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_byte_tx;

  localparam int C_DIV      = 4;
  localparam int C_FRAME    = 42 * C_DIV;
`ifdef I2C_STRETCH_EN
  localparam int C_STRETCH  = C_FRAME + 10;
`else
  localparam int C_STRETCH  = C_FRAME;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       sda_in;
  logic       scl_in;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       ack_err;

  i2c_byte_tx #(.CLK_DIV(C_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data    (data),
    .sda_in  (sda_in),
    .scl_in  (scl_in),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       ack;       // sda_in level during the ACK slot
    logic       stretch;   // hold scl_in low 10 cycles in the last bit's Q2
    int         poke;      // frame cycle to pulse start with 0xFF, -1 = none
    int         exp_busy;
    logic       exp_err;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Per-cycle observation state
  logic       prev_scl = 1'b0;
  int         rel_n;
  logic [7:0] rel_bits;
  int         done_cnt;
  int         busy_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; observe outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    if (prev_scl && !scl_oe && busy && rel_n < 8) begin
      rel_bits = {rel_bits[6:0], ~sda_oe};
      rel_n++;
    end
    prev_scl = scl_oe;
  endtask

  // Send one byte starting now; returns in the first non-busy cycle.
  task automatic send(input logic [7:0] d, input logic ack, input logic stretch,
                      input int poke, input string tag);
    int idx;
    data     = d;
    sda_in   = ack;
    start    = 1'b1;
    done_cnt = 0;
    step();
    start    = 1'b0;
    data     = ~d;
    rel_n    = 0;
    rel_bits = 8'h00;
    chk({tag, " busy after accept"}, 32'(busy), 32'd1);
    chk({tag, " ack_err cleared"}, 32'(ack_err), 32'd0);
    busy_cnt = 1;
    idx      = 0;
    while (busy && idx < 1000) begin
      scl_in = (stretch && idx >= 128 && idx < 138) ? 1'b0 : 1'b1;
      if (idx == poke) begin
        start = 1'b1;
        data  = 8'hFF;
      end else begin
        start = 1'b0;
      end
      step();
      idx++;
      if (busy) busy_cnt++;
    end
    start  = 1'b0;
    scl_in = 1'b1;
    if (idx >= 1000) chk({tag, " frame timeout"}, 32'd1, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int idle_busy;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, -1, C_FRAME,   1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, -1, C_FRAME,   1'b1};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, -1, C_FRAME,   1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, -1, C_FRAME,   1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, -1, C_FRAME,   1'b1};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 20, C_FRAME,   1'b0};
    vecs[6] = '{8'h81, 1'b0, 1'b1, -1, C_STRETCH, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    data     = 8'h00;
    sda_in   = 1'b1;
    scl_in   = 1'b1;
    done_cnt = 0;
    rel_n    = 0;
    rel_bits = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset scl_oe",  32'(scl_oe),  32'd0);
    chk("reset sda_oe",  32'(sda_oe),  32'd0);
    chk("reset busy",    32'(busy),    32'd0);
    chk("reset done",    32'(done),    32'd0);
    chk("reset ack_err", 32'(ack_err), 32'd0);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      send(vecs[i].data, vecs[i].ack, vecs[i].stretch, vecs[i].poke, tag);
      chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(vecs[i].exp_busy));
      chk({tag, " sda bits"},    32'(rel_bits), 32'(vecs[i].data));
      chk({tag, " done now"},    32'(done),     32'd1);
      sda_in    = 1'b1;
      idle_busy = 0;
      repeat (20) begin
        step();
        if (busy) idle_busy++;
      end
      chk({tag, " done pulses"}, 32'(done_cnt),  32'd1);
      chk({tag, " idle busy"},   32'(idle_busy), 32'd0);
      chk({tag, " ack_err"},     32'(ack_err),   32'(vecs[i].exp_err));
    end

    // Reset in the middle of the fourth data bit: abort, no STOP, no done.
    data     = 8'hA5;
    sda_in   = 1'b0;
    start    = 1'b1;
    done_cnt = 0;
    step();
    start = 1'b0;
    repeat (8 + 16 * 3 + 5) step();
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort scl_oe", 32'(scl_oe), 32'd0);
    chk("abort sda_oe", 32'(sda_oe), 32'd0);
    chk("abort busy",   32'(busy),   32'd0);
    idle_busy = 0;
    repeat (200) begin
      step();
      if (busy || scl_oe || sda_oe) idle_busy++;
    end
    chk("abort done pulses", 32'(done_cnt),  32'd0);
    chk("abort bus idle",    32'(idle_busy), 32'd0);

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst over start busy", 32'(busy), 32'd0);
    step();
    chk("rst over start idle", 32'(busy), 32'd0);

    // Back-to-back: second start issued in the done cycle of the first.
    send(8'hA5, 1'b0, 1'b0, -1, "b2b first");
    chk("b2b done cycle", 32'(done), 32'd1);
    send(8'h00, 1'b0, 1'b0, -1, "b2b second");
    chk("b2b second busy", 32'(busy_cnt), 32'(C_FRAME));
    chk("b2b second bits", 32'(rel_bits), 32'h00);
    chk("b2b second nbits", 32'(rel_n),   32'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
